bounce_box_overlay: RTL

Pixel-domain overlay stage between the test-pattern generator and the three TMDS encoders in the 720p HDMI path. It takes the pixel timing (sx, sy, hsync, vsync, de) and the pattern RGB, and draws a solid box over the pattern. The box moves a fixed step every frame and bounces off the active-area edges. Timing and colour leave the block delayed by the same fixed latency, so the encoders see aligned control and data.

---
 rtl/video_pkg.sv | 21 ++
 rtl/bounce_axis.sv | 61 ++++++
 rtl/bounce_box_overlay.sv | 109 ++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared 720p video definitions for the HDMI pixel path.
package video_pkg;

    localparam int H_ACTIVE    = 1280;
    localparam int V_ACTIVE    = 720;
    localparam int H_TOTAL     = 1650;
    localparam int V_TOTAL     = 750;
    localparam int COLOUR_BITS = 8;

    typedef struct packed {
        logic [COLOUR_BITS-1:0] r;
        logic [COLOUR_BITS-1:0] g;
        logic [COLOUR_BITS-1:0] b;
    } rgb_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position and travel direction, stepped on tick,
// clamped and reversed at 0 and LIMIT-SIZE.
module bounce_axis
    import video_pkg::*;
#(
    parameter int LIMIT = 1280,
    parameter int SIZE  = 64,
    parameter int STEP  = 4,
    parameter int W     = 11
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_tick,
    output logic [W-1:0] o_pos,
    output logic         o_dir
);

    // One extra bit so pos+STEP can never wrap before the compare.
    localparam logic [W:0] MAX_POS = (W+1)'(LIMIT - SIZE);
    localparam logic [W:0] STEP_X  = (W+1)'(STEP);

    logic [W-1:0] pos_q, pos_d;
    dir_e         dir_q, dir_d;
    logic [W:0]   pos_x, sum;

    always_comb begin
        pos_x = {1'b0, pos_q};
        sum   = pos_x + STEP_X;
        pos_d = pos_q;
        dir_d = dir_q;
        if (i_tick) begin
            if (dir_q == DIR_INC) begin
                if (sum >= MAX_POS) begin
                    pos_d = MAX_POS[W-1:0];
                    dir_d = DIR_DEC;
                end else begin
                    pos_d = sum[W-1:0];
                end
            end else if (pos_x <= STEP_X) begin
                pos_d = '0;
                dir_d = DIR_INC;
            end else begin
                pos_d = pos_q - STEP_X[W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pos_q <= '0;
            dir_q <= DIR_INC;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign o_pos = pos_q;
    assign o_dir = (dir_q == DIR_DEC);

endmodule

// File: rtl/bounce_box_overlay.sv
// Draws a solid box that bounces around the active area over the pattern
// colour; timing and colour both leave through the same 2-stage pipeline.
module bounce_box_overlay
    import video_pkg::*;
#(
    parameter int                       H_ACTIVE    = video_pkg::H_ACTIVE,
    parameter int                       V_ACTIVE    = video_pkg::V_ACTIVE,
    parameter int                       SX_W        = 11,
    parameter int                       SY_W        = 10,
    parameter int                       COLOUR_BITS = video_pkg::COLOUR_BITS,
    parameter int                       BOX_SIZE    = 64,
    parameter int                       STEP        = 4,
    parameter logic [3*COLOUR_BITS-1:0] BOX_RGB     = 24'hFF_FF_00
) (
    input  logic                   i_clk_pxl,
    input  logic                   i_reset,
    input  logic [SX_W-1:0]        i_sx,
    input  logic [SY_W-1:0]        i_sy,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic                   i_de,
    input  logic [COLOUR_BITS-1:0] i_red,
    input  logic [COLOUR_BITS-1:0] i_green,
    input  logic [COLOUR_BITS-1:0] i_blue,
    input  logic                   i_enable,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic [COLOUR_BITS-1:0] o_red,
    output logic [COLOUR_BITS-1:0] o_green,
    output logic [COLOUR_BITS-1:0] o_blue,
    output logic [SX_W-1:0]        o_box_x,
    output logic [SY_W-1:0]        o_box_y
);

    localparam int CW = 3 * COLOUR_BITS;

    logic            tick, move;
    logic            en_q, en_d;
    logic [SX_W-1:0] box_x;
    logic [SY_W-1:0] box_y;
    logic            unused_dir_x, unused_dir_y;
    logic            in_box;

    logic [2:0]    s1_sync_q, s1_sync_d;
    logic [CW-1:0] s1_rgb_q, s1_rgb_d;
    logic          s1_in_box_q, s1_in_box_d;
    logic [2:0]    s2_sync_q, s2_sync_d;
    logic [CW-1:0] s2_rgb_q, s2_rgb_d;

    // First blanking line, first pixel: box state only changes here so a
    // frame is never drawn with two positions.
    assign tick = (i_sx == '0) && (i_sy == SY_W'(V_ACTIVE));
    assign en_d = tick ? i_enable : en_q;
    assign move = tick && i_enable;

    bounce_axis #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP), .W(SX_W)) u_axis_x (
        .i_clk   (i_clk_pxl),
        .i_reset (i_reset),
        .i_tick  (move),
        .o_pos   (box_x),
        .o_dir   (unused_dir_x)
    );

    bounce_axis #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP), .W(SY_W)) u_axis_y (
        .i_clk   (i_clk_pxl),
        .i_reset (i_reset),
        .i_tick  (move),
        .o_pos   (box_y),
        .o_dir   (unused_dir_y)
    );

    always_comb begin
        in_box = i_de && en_q
            && ({1'b0, box_x} <= {1'b0, i_sx})
            && ({1'b0, i_sx}  <  {1'b0, box_x} + (SX_W+1)'(BOX_SIZE))
            && ({1'b0, box_y} <= {1'b0, i_sy})
            && ({1'b0, i_sy}  <  {1'b0, box_y} + (SY_W+1)'(BOX_SIZE));
        s1_sync_d   = {i_hsync, i_vsync, i_de};
        s1_rgb_d    = {i_red, i_green, i_blue};
        s1_in_box_d = in_box;
        s2_sync_d   = s1_sync_q;
        s2_rgb_d    = s1_in_box_q ? BOX_RGB : s1_rgb_q;
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            en_q        <= 1'b0;
            s1_sync_q   <= '0;
            s1_rgb_q    <= '0;
            s1_in_box_q <= 1'b0;
            s2_sync_q   <= '0;
            s2_rgb_q    <= '0;
        end else begin
            en_q        <= en_d;
            s1_sync_q   <= s1_sync_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_in_box_q <= s1_in_box_d;
            s2_sync_q   <= s2_sync_d;
            s2_rgb_q    <= s2_rgb_d;
        end
    end

    assign {o_hsync, o_vsync, o_de}  = s2_sync_q;
    assign {o_red, o_green, o_blue}  = s2_rgb_q;
    assign o_box_x = box_x;
    assign o_box_y = box_y;

endmodule
